// File: rtl/gesture_input_encoder.sv
// Per-player gesture encoder: sync + debounce three buttons, reject multi-press, hold a locked code.
// Optional GESTURE_AUTO_EN adds an AUTO input and an LFSR-driven computer opponent.
module gesture_input_encoder #(
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] BTN,
`ifdef GESTURE_AUTO_EN
    input  logic       AUTO,
`endif
    output logic [0:1] GOUT,
    output logic       VALID,
    output logic       ERR
);

    localparam int unsigned NB = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK,
        ST_RELEASE,
        ST_ERROR
    } state_t;

    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    db;
    logic [NB-1:0]    db_d;
    logic [NB-1:0]    press;
    logic [CNT_W-1:0] db_cnt [NB];

    state_t           state_q;
    state_t           state_d;
    logic [0:1]       gout_q;
    logic [0:1]       gout_d;
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic [0:1]       press_code_c;
    logic             auto_c;
    logic [0:1]       auto_code_c;

    // Two-flop synchroniser per button
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    // Debounce with saturating counters; press pulse is registered one cycle after the debounced rise
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_d  <= db;
            press <= db & ~db_d;
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= CNT_W'(DB_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != '1) begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef GESTURE_AUTO_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1, free running
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign auto_c      = AUTO;
    assign auto_code_c = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
`else
    assign auto_c      = 1'b0;
    assign auto_code_c = 2'b00;
`endif

    always_comb begin
        case (press)
            3'b001:  press_code_c = 2'b01;
            3'b010:  press_code_c = 2'b10;
            3'b100:  press_code_c = 2'b11;
            default: press_code_c = 2'b00;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            gout_q  <= 2'b00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gout_q  <= gout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gout_d  = gout_q;
        valid_d = valid_q;
        err_d   = err_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (auto_c) begin
                    state_d = ST_LOCK;
                    gout_d  = auto_code_c;
                    valid_d = 1'b1;
                    hold_d  = CNT_W'(HOLD_CYCLES - 1);
                end else if (press != '0) begin
                    // a lone press with nothing else held locks; anything else is a multi-press
                    if ($onehot(press) && ((db & ~press) == '0)) begin
                        state_d = ST_LOCK;
                        gout_d  = press_code_c;
                        valid_d = 1'b1;
                        hold_d  = CNT_W'(HOLD_CYCLES - 1);
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_LOCK: begin
                if (hold_q == '0) begin
                    state_d = ST_RELEASE;
                    gout_d  = 2'b00;
                    valid_d = 1'b0;
                end else begin
                    hold_d = hold_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (auto_c || (db == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (db == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gout_d  = 2'b00;
                valid_d = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign GOUT  = gout_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

endmodule

// File: doc/gesture_input_encoder.md
Name: gesture_input_encoder

Overview:
Generates one player's 2-bit gesture code from three raw push buttons (scissors/rock/paper) for the Muk-jji-ppa main FSM and series detector.
- Synchronises and debounces the buttons.
- Rejects multi-button presses.
- Drives a stable code for a guaranteed hold window, then returns to "no gesture".
- The top level instantiates two copies, one driving AIN and one driving BIN.

Parameters:
DB_CYCLES, 4, consecutive stable synchronised samples required before a button's debounced state changes (>=1)
HOLD_CYCLES, 8, minimum cycles a locked gesture is driven on GOUT (>=1)
CNT_W, 8, width of the debounce and hold counters; must hold max(DB_CYCLES, HOLD_CYCLES)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
BTN  input  3  raw buttons, asynchronous, active-high; bit 0 = scissors, bit 1 = rock, bit 2 = paper
GOUT  output  [0:1]  gesture code (bit 0 is MSB): 00 none, 01 scissors, 10 rock, 11 paper
VALID  output  1  high while GOUT holds a locked gesture
ERR  output  1  high while in the multi-press error state

Behaviour:
- Reset (RST=0, async): all registers clear; GOUT=00, VALID=0, ERR=0; synchronisers and debounced states=0; counters=0; FSM=IDLE.
- Synchroniser: 2-FF chain per button. Only the second stage is used downstream.
- Debounce, per button:
  - Counter increments while the synced value differs from the debounced state.
  - Counter clears whenever the two agree.
  - After DB_CYCLES consecutive differing samples, the debounced state takes the synced value and the counter clears.
  - A glitch shorter than DB_CYCLES samples never changes the debounced state.
- Press event: single-cycle pulse per button on a debounced 0->1 transition.
- FSM, all outputs registered:
  - IDLE: GOUT=00, VALID=0, ERR=0.
    - Exactly one press event and no other debounced button high -> LOCK: GOUT=code, VALID=1, hold counter loaded with HOLD_CYCLES-1.
    - A press event while any other debounced button is high, or two or more simultaneous press events -> ERROR.
  - LOCK: GOUT and VALID held constant.
    - Hold counter decrements each cycle.
    - A press on another button during LOCK is ignored; the code never changes mid-hold.
    - Counter=0 -> RELEASE.
  - RELEASE: GOUT=00, VALID=0.
    - Stays until all debounced buttons are 0, then -> IDLE.
    - A still-held button therefore never re-triggers.
  - ERROR: GOUT=00, VALID=0, ERR=1.
    - Stays until all debounced buttons are 0, then -> IDLE.
- Latency: a clean press stable from edge t gives GOUT valid after edge t+2+DB_CYCLES+1. GOUT stays valid for exactly HOLD_CYCLES cycles.
- GOUT is never driven 00 together with VALID=1, and never changes value other than at a LOCK entry or exit.
- Reset mid-LOCK: GOUT drops to 00 immediately (async); no residual state after release.
- Counters saturate, never wrap. Parameter values exceeding 2^CNT_W-1 are illegal (bench asserts).

Optional Feature:
GESTURE_AUTO_EN: when defined, adds input AUTO (1 bit) and an 8-bit LFSR.
- LFSR taps x^8+x^6+x^5+x^4+1; reset seed 8'hA5; advances every cycle.
- While AUTO=1 and FSM=IDLE, an automatic press is taken next cycle with code = lfsr[1:0], where 00 maps to 01. BTN press events are ignored.
- RELEASE exits to IDLE immediately, without waiting for button release.
- The AUTO mode gives a computer opponent.
- Without the macro: no AUTO port, no LFSR; behaviour exactly as above.

Test Plan:
- Reset: RST=0 with BTN=111 -> GOUT=00, VALID=0, ERR=0. Release RST with BTN=000 -> outputs stay 0 for 20 cycles.
- Clean rock (DB_CYCLES=4, HOLD_CYCLES=8): BTN=010 from edge t -> GOUT=10, VALID=1 at edge t+7 for exactly 8 cycles, then GOUT=00. No re-trigger while held; a new press after release works.
- Glitch: BTN[0] high for 3 cycles -> GOUT stays 00 and VALID stays 0 throughout.
- Multi-press: BTN=011 set together -> ERR=1, GOUT=00. ERR clears one cycle after both debounced states drop. A following paper press then gives GOUT=11.
- Mid-hold press and reset: lock scissors (01), press paper during LOCK -> GOUT stays 01. Assert RST mid-hold -> GOUT=00 asynchronously.
- GESTURE_AUTO_EN: AUTO=1 after reset -> first GOUT code matches the model LFSR from seed A5. Codes repeat with a period of 8+2 cycles and GOUT is never 00 while VALID=1.
